// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM slave with optional wait states and a
// two-cycle ERROR response for illegal transfers.
// Ports:
//   HCLK, HRST_N      - clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE - address-phase controls
//   HWDATA            - write data (data phase)
//   HREADY            - bus-level ready from the read mux
//   HREADYOUT         - this slave's ready
//   HRDATA, HRESP     - read data and response (0 = OKAY, 1 = ERROR)
// Configuration macro: AHB_SLAVE_WAIT_EN adds the WAIT state and the
// wait-state counter (effective wait count = WAIT_CYCLES); otherwise every
// OKAY transfer completes with zero wait states.

`ifndef AHB_BUS_WIDTH
`define AHB_BUS_WIDTH 32
`endif

module ahb_sram_slave #(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                      HCLK,
  input  logic                      HRST_N,
  input  logic                      HSEL,
  input  logic [`AHB_BUS_WIDTH-1:0] HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HWRITE,
  input  logic [2:0]                HSIZE,
  input  logic [`AHB_BUS_WIDTH-1:0] HWDATA,
  input  logic                      HREADY,
  output logic                      HREADYOUT,
  output logic [`AHB_BUS_WIDTH-1:0] HRDATA,
  output logic                      HRESP
);

  localparam int unsigned DW = `AHB_BUS_WIDTH;
  localparam int unsigned NB = 4;
  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

`ifdef AHB_SLAVE_WAIT_EN
  localparam int unsigned EFF_WAIT = WAIT_CYCLES;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0, S_WAIT = 2'd1, S_ERR1 = 2'd2, S_ERR2 = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0, S_ERR1 = 2'd2, S_ERR2 = 2'd3
  } state_e;
`endif

  state_e          state_q;
  logic            hready_q;
  logic            hresp_q;
  logic [DW-1:0]   rdata_q;
  logic            dphase_q;   // OKAY data phase in progress
  logic            write_q;
  logic [AW-1:0]   idx_q;
  logic [NB-1:0]   be_q;
`ifdef AHB_SLAVE_WAIT_EN
  logic [3:0]      cnt_q;
`endif

  logic [DW-1:0]   mem_q [MEM_DEPTH];

  logic            accept_c;
  logic            err_c;
  logic [NB-1:0]   lanes_c;
  logic [AW-1:0]   idx_c;
  logic            commit_c;
  logic [DW-1:0]   wr_word_c;
  logic [DW-1:0]   fwd_c;
  logic            unused_c;

  assign HREADYOUT = hready_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = rdata_q;

  // HTRANS[0] only distinguishes NONSEQ/SEQ and IDLE/BUSY, which behave alike here.
`ifdef AHB_SLAVE_WAIT_EN
  assign unused_c = HTRANS[0];
`else
  assign unused_c = HTRANS[0] ^ (WAIT_CYCLES != 0);
`endif

  assign accept_c = HSEL & HTRANS[1] & HREADY;
  assign idx_c    = HADDR[AW+1:2];
  // A write lands on the edge that ends its data phase.
  assign commit_c = dphase_q & write_q & hready_q;

  // Illegal-transfer decode and byte-lane selection for the address phase.
  always_comb begin
    err_c   = 1'b0;
    lanes_c = 4'b1111;
    if (HADDR[DW-1:2] >= (DW-2)'(MEM_DEPTH)) err_c = 1'b1;
    if (HSIZE > 3'd2) err_c = 1'b1;
    if ((HSIZE == 3'd1) && HADDR[0]) err_c = 1'b1;
    if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00)) err_c = 1'b1;
    case (HSIZE)
      3'd0:    lanes_c = 4'b0001 << HADDR[1:0];
      3'd1:    lanes_c = HADDR[1] ? 4'b1100 : 4'b0011;
      default: lanes_c = 4'b1111;
    endcase
  end

  // Merge the pending write into the stored word, little-endian lanes.
  always_comb begin
    wr_word_c = mem_q[idx_q];
    for (int b = 0; b < NB; b++) begin
      if (be_q[b]) wr_word_c[8*b +: 8] = HWDATA[8*b +: 8];
    end
  end

  // A read accepted on a write's commit edge to the same word sees the new data.
  assign fwd_c = (commit_c && (idx_q == idx_c)) ? wr_word_c : mem_q[idx_c];

  // Storage is intentionally not reset.
  always_ff @(posedge HCLK) begin
    if (commit_c) mem_q[idx_q] <= wr_word_c;
  end

  // Transfer state machine with registered HREADYOUT/HRESP/HRDATA.
  always_ff @(posedge HCLK or negedge HRST_N) begin
    if (!HRST_N) begin
      state_q  <= S_IDLE;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      rdata_q  <= '0;
      dphase_q <= 1'b0;
      write_q  <= 1'b0;
      idx_q    <= '0;
      be_q     <= '0;
`ifdef AHB_SLAVE_WAIT_EN
      cnt_q    <= 4'd0;
`endif
    end else begin
      case (state_q)
        S_ERR1: begin
          state_q  <= S_ERR2;
          hready_q <= 1'b1;
        end
`ifdef AHB_SLAVE_WAIT_EN
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q  <= S_IDLE;
            hready_q <= 1'b1;
          end
        end
`endif
        default: begin
          // IDLE or ERR2: HREADYOUT is high, so any current data phase ends here.
          state_q  <= S_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
          rdata_q  <= '0;
          dphase_q <= 1'b0;
          if (accept_c) begin
            if (err_c) begin
              state_q  <= S_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= 1'b1;
            end else begin
              dphase_q <= 1'b1;
              write_q  <= HWRITE;
              idx_q    <= idx_c;
              be_q     <= lanes_c;
              if (!HWRITE) rdata_q <= fwd_c;
`ifdef AHB_SLAVE_WAIT_EN
              if (EFF_WAIT != 0) begin
                state_q  <= S_WAIT;
                hready_q <= 1'b0;
                cnt_q    <= 4'(EFF_WAIT);
              end
`endif
            end
          end
        end
      endcase
    end
  end

endmodule
